// File: rtl/tfacc_chparam_prefetch.sv
// Double-buffered bias/quant fetcher: streams NCH channel word pairs
// into a back buffer while the i8mac lanes read the front buffer.
module tfacc_chparam_prefetch #(
   parameter int NCH = 4,
   parameter int CW  = 12
) (
   input  logic              aclk,
   input  logic              arst_n,
   input  logic              flush,
   input  logic              req,
   input  logic [CW-1:0]     req_ch,
   output logic              req_rdy,
   output logic [31:0]       d_adr,
   output logic              d_re,
   input  logic              d_rdy,
   input  logic [31:0]       d_dr,
   output logic [31:0]       e_adr,
   output logic              e_re,
   input  logic              e_rdy,
   input  logic [31:0]       e_dr,
   output logic [NCH*32-1:0] bias,
   output logic [NCH*32-1:0] quant,
   output logic              pvalid,
   input  logic              consume,
   output logic              busy
);

   localparam int IW = $clog2(NCH) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN
   } state_t;

   state_t state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [CW-1:0] base_q, base_d;
   logic back_full_q, back_full_d;
   logic pvalid_q, pvalid_d;
   logic [NCH-1:0][31:0] bb_q, bb_d;
   logic [NCH-1:0][31:0] bq_q, bq_d;
   logic [NCH-1:0][31:0] fb_q, fb_d;
   logic [NCH-1:0][31:0] fq_q, fq_d;

   logic step, accept, cap_en, set_full, swap;
   logic [IW-1:0] cap_sel;
   logic [CW-1:0] ch;

   assign step    = d_rdy & e_rdy;
   assign req_rdy = (state_q == S_IDLE) & ~back_full_q;
   assign accept  = req & req_rdy;
   assign busy    = (state_q != S_IDLE);
   assign d_re    = busy;
   assign e_re    = busy;
   assign ch      = base_q + CW'(idx_q);
   assign d_adr   = busy ? {{(30-CW){1'b0}}, ch, 2'b00} : '0;
   assign e_adr   = d_adr;
   assign bias    = fb_q;
   assign quant   = fq_q;
   assign pvalid  = pvalid_q;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      base_d   = base_q;
      cap_en   = 1'b0;
      cap_sel  = idx_q - IW'(1);
      set_full = 1'b0;
      unique case (1'b1)
         (state_q == S_IDLE): begin
            if (accept) begin
               state_d = S_FETCH;
               base_d  = req_ch;
               idx_d   = '0;
            end
         end
         (state_q == S_FETCH): begin
            if (step) begin
               // data returned now belongs to the previous index
               cap_en = (idx_q != '0);
               if (idx_q == IW'(NCH-1)) begin
                  state_d = S_DRAIN;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         (state_q == S_DRAIN): begin
            if (step) begin
               cap_en   = 1'b1;
               cap_sel  = IW'(NCH-1);
               set_full = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         state_d = S_IDLE;
         idx_d   = '0;
      end
   end

   always_comb begin
      bb_d = bb_q;
      bq_d = bq_q;
      for (int c = 0; c < NCH; c++) begin
         if (cap_en && cap_sel == IW'(c)) begin
            bb_d[c] = d_dr;
            bq_d[c] = e_dr;
         end
      end
   end

   always_comb begin
      swap        = back_full_q & (~pvalid_q | consume);
      back_full_d = back_full_q;
      pvalid_d    = pvalid_q;
      fb_d        = fb_q;
      fq_d        = fq_q;
      if (swap) begin
         fb_d        = bb_q;
         fq_d        = bq_q;
         pvalid_d    = 1'b1;
         back_full_d = 1'b0;
      end else if (consume) begin
         pvalid_d = 1'b0;
      end
      // back_full is clear throughout DRAIN, so no swap can coincide
      if (set_full) begin
         back_full_d = 1'b1;
      end
      if (flush) begin
         back_full_d = 1'b0;
         pvalid_d    = 1'b0;
      end
   end

   always_ff @(posedge aclk) begin
      if (!arst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         base_q      <= '0;
         back_full_q <= 1'b0;
         pvalid_q    <= 1'b0;
         bb_q        <= '0;
         bq_q        <= '0;
         fb_q        <= '0;
         fq_q        <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         base_q      <= base_d;
         back_full_q <= back_full_d;
         pvalid_q    <= pvalid_d;
         bb_q        <= bb_d;
         bq_q        <= bq_d;
         fb_q        <= fb_d;
         fq_q        <= fq_d;
      end
   end

endmodule

// File: tb/tb_tfacc_chparam_prefetch.sv
// Bench for tfacc_chparam_prefetch: cache responder plus a group-level
// reference model of addresses, lane contents and pvalid timing.
module tb_tfacc_chparam_prefetch;

   localparam int NCH = 4;
   localparam int CW  = 12;

   logic aclk = 1'b0;
   logic arst_n, flush, req, d_rdy, e_rdy, consume;
   logic [CW-1:0] req_ch;
   logic req_rdy, d_re, e_re, pvalid, busy;
   logic [31:0] d_adr, e_adr, d_dr, e_dr;
   logic [NCH*32-1:0] bias, quant;

   int ncmp = 0;
   int nerr = 0;
   logic [31:0] bbase, qbase;

   always #5 aclk = ~aclk;

   tfacc_chparam_prefetch #(.NCH(NCH), .CW(CW)) dut (
      .aclk(aclk), .arst_n(arst_n), .flush(flush),
      .req(req), .req_ch(req_ch), .req_rdy(req_rdy),
      .d_adr(d_adr), .d_re(d_re), .d_rdy(d_rdy), .d_dr(d_dr),
      .e_adr(e_adr), .e_re(e_re), .e_rdy(e_rdy), .e_dr(e_dr),
      .bias(bias), .quant(quant), .pvalid(pvalid),
      .consume(consume), .busy(busy)
   );

   function automatic logic [31:0] bword(input logic [CW-1:0] ch);
      return bbase + 32'(ch);
   endfunction

   function automatic logic [31:0] qword(input logic [CW-1:0] ch);
      return qbase ^ 32'(ch);
   endfunction

   function automatic logic [31:0] adr_of(input logic [CW-1:0] ch);
      return 32'({ch, 2'b00});
   endfunction

   // one clock; the cache returns data for the address seen in a step cycle
   task automatic tick();
      logic st;
      logic [31:0] da, ea;
      st = d_rdy & e_rdy;
      da = d_adr;
      ea = e_adr;
      @(posedge aclk);
      #1;
      if (st) begin
         d_dr = bword(da[CW+1:2]);
         e_dr = qword(ea[CW+1:2]);
      end
   endtask

   task automatic drain_front();
      for (int i = 0; i < 4 && pvalid === 1'b1; i++) begin
         consume = 1'b1;
         tick();
      end
      consume = 1'b0;
   endtask

   // mode 0: always ready, 1: e_rdy low in cycles 2-4, 2: random stalls
   task automatic fetch_group(input logic [CW-1:0] r, input int mode,
                              input int exp_cyc);
      logic [31:0] adrs[$];
      logic [CW-1:0] ch;
      int steps, last, got, k;
      steps = 0; last = -100; got = -1; k = 1;
      ncmp++;
      if (req_rdy !== 1'b1) begin
         nerr++;
         $display("FAIL pre_req_rdy r=%h got %b want 1", r, req_rdy);
      end
      req = 1'b1; req_ch = r; d_rdy = 1'b1; e_rdy = 1'b1;
      tick();
      req = 1'b0;
      ncmp++;
      if ({busy, req_rdy} !== 2'b10) begin
         nerr++;
         $display("FAIL cyc1_busy r=%h got %b want 10", r, {busy, req_rdy});
      end
      while (k <= 200 && got < 0) begin
         if (pvalid === 1'b1) begin
            got = k;
         end else begin
            case (mode)
               0: begin d_rdy = 1'b1; e_rdy = 1'b1; end
               1: begin d_rdy = 1'b1; e_rdy = !(k >= 2 && k <= 4); end
               default: begin
                  d_rdy = ($urandom_range(3) != 0);
                  e_rdy = ($urandom_range(3) != 0);
               end
            endcase
            if (d_rdy && e_rdy && d_re === 1'b1) begin
               adrs.push_back(d_adr);
               steps++;
               if (steps == NCH + 1) last = k;
               ncmp++;
               if (e_adr !== d_adr) begin
                  nerr++;
                  $display("FAIL e_adr k=%0d got %h want %h", k, e_adr, d_adr);
               end
            end
            tick();
            k++;
         end
      end
      d_rdy = 1'b1; e_rdy = 1'b1;
      ncmp++;
      if (got != last + 2) begin
         nerr++;
         $display("FAIL pvalid_cyc r=%h got %0d want %0d", r, got, last + 2);
      end
      if (exp_cyc >= 0) begin
         ncmp++;
         if (got != exp_cyc) begin
            nerr++;
            $display("FAIL pvalid_lat r=%h got %0d want %0d", r, got, exp_cyc);
         end
      end
      ncmp++;
      if (adrs.size() != NCH + 1) begin
         nerr++;
         $display("FAIL n_steps r=%h got %0d want %0d", r, adrs.size(), NCH + 1);
      end else begin
         for (int i = 0; i <= NCH; i++) begin
            ch = r + CW'((i < NCH) ? i : NCH - 1);
            ncmp++;
            if (adrs[i] !== adr_of(ch)) begin
               nerr++;
               $display("FAIL adr r=%h i=%0d got %h want %h", r, i, adrs[i], adr_of(ch));
            end
         end
      end
      for (int c = 0; c < NCH; c++) begin
         ch = r + CW'(c);
         ncmp++;
         if (bias[c*32 +: 32] !== bword(ch) || quant[c*32 +: 32] !== qword(ch)) begin
            nerr++;
            $display("FAIL lane r=%h c=%0d got %h/%h want %h/%h", r, c,
                     bias[c*32 +: 32], quant[c*32 +: 32], bword(ch), qword(ch));
         end
      end
   endtask

   task automatic check_reset_vals(input string tag);
      ncmp++;
      if ({req_rdy, d_re, e_re, busy, pvalid} !== 5'b10000) begin
         nerr++;
         $display("FAIL %s_ctl got %b want 10000", tag, {req_rdy, d_re, e_re, busy, pvalid});
      end
      ncmp++;
      if (d_adr !== 32'h0 || e_adr !== 32'h0) begin
         nerr++;
         $display("FAIL %s_adr got %h/%h want 0/0", tag, d_adr, e_adr);
      end
      ncmp++;
      if (bias !== '0 || quant !== '0) begin
         nerr++;
         $display("FAIL %s_data got %h/%h want 0", tag, bias, quant);
      end
   endtask

   task automatic test_reset();
      arst_n = 1'b0; flush = 1'b0; req = 1'b0; consume = 1'b0;
      d_rdy = 1'b1; e_rdy = 1'b1; req_ch = '0; d_dr = '0; e_dr = '0;
      bbase = 32'h100; qbase = 32'h8000_0000;
      tick(); tick();
      check_reset_vals("reset");
      arst_n = 1'b1;
      tick();
      check_reset_vals("post_reset");
   endtask

   task automatic test_basic();
      bbase = 32'h100; qbase = 32'h8000_0000;
      fetch_group(12'h010, 0, NCH + 3);
      drain_front();
   endtask

   task automatic test_stall();
      bbase = 32'h100; qbase = 32'h8000_0000;
      fetch_group(12'h010, 1, 10);
      drain_front();
   endtask

   task automatic test_wrap();
      bbase = $urandom; qbase = $urandom;
      fetch_group(12'hFFE, 0, NCH + 3);
   endtask

   task automatic test_back_to_back();
      logic [CW-1:0] ra, rb, ch;
      ra = 12'hFFE;
      rb = CW'($urandom);
      req = 1'b1; req_ch = rb;
      tick();
      req = 1'b0;
      for (int i = 0; i < NCH + 4; i++) tick();
      ncmp++;
      if ({req_rdy, pvalid, busy} !== 3'b010) begin
         nerr++;
         $display("FAIL b2b_hold got %b want 010", {req_rdy, pvalid, busy});
      end
      for (int c = 0; c < NCH; c++) begin
         ch = ra + CW'(c);
         ncmp++;
         if (bias[c*32 +: 32] !== bword(ch)) begin
            nerr++;
            $display("FAIL b2b_frontA c=%0d got %h want %h", c, bias[c*32 +: 32], bword(ch));
         end
      end
      consume = 1'b1;
      tick();
      consume = 1'b0;
      ncmp++;
      if ({req_rdy, pvalid} !== 2'b11) begin
         nerr++;
         $display("FAIL b2b_swap got %b want 11", {req_rdy, pvalid});
      end
      for (int c = 0; c < NCH; c++) begin
         ch = rb + CW'(c);
         ncmp++;
         if (bias[c*32 +: 32] !== bword(ch) || quant[c*32 +: 32] !== qword(ch)) begin
            nerr++;
            $display("FAIL b2b_frontB c=%0d got %h/%h want %h/%h", c,
                     bias[c*32 +: 32], quant[c*32 +: 32], bword(ch), qword(ch));
         end
      end
      tick();
      ncmp++;
      if (pvalid !== 1'b1) begin
         nerr++;
         $display("FAIL b2b_keep got %b want 1", pvalid);
      end
   endtask

   task automatic test_consume_empty();
      consume = 1'b1;
      tick();
      ncmp++;
      if (pvalid !== 1'b0) begin
         nerr++;
         $display("FAIL release got %b want 0", pvalid);
      end
      tick();
      consume = 1'b0;
      ncmp++;
      if ({pvalid, req_rdy} !== 2'b01) begin
         nerr++;
         $display("FAIL release_idle got %b want 01", {pvalid, req_rdy});
      end
   endtask

   task automatic test_flush();
      logic [CW-1:0] rb;
      bbase = $urandom; qbase = $urandom;
      fetch_group(CW'($urandom), 0, -1);
      rb = CW'($urandom);
      req = 1'b1; req_ch = rb;
      tick();
      req = 1'b0;
      tick(); tick();
      ncmp++;
      if (d_adr !== adr_of(rb + CW'(2))) begin
         nerr++;
         $display("FAIL flush_idx2 got %h want %h", d_adr, adr_of(rb + CW'(2)));
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      ncmp++;
      if ({busy, pvalid, d_re, e_re, req_rdy} !== 5'b00001) begin
         nerr++;
         $display("FAIL flush got %b want 00001", {busy, pvalid, d_re, e_re, req_rdy});
      end
      fetch_group(CW'($urandom), 2, -1);
      drain_front();
   endtask

   task automatic test_reset_drain();
      logic [CW-1:0] r;
      r = CW'($urandom);
      req = 1'b1; req_ch = r;
      tick();
      req = 1'b0;
      for (int i = 0; i < NCH; i++) tick();
      ncmp++;
      if (busy !== 1'b1 || d_adr !== adr_of(r + CW'(NCH - 1))) begin
         nerr++;
         $display("FAIL drain_adr got %b/%h want 1/%h", busy, d_adr, adr_of(r + CW'(NCH - 1)));
      end
      arst_n = 1'b0;
      tick();
      check_reset_vals("drain_reset");
      arst_n = 1'b1;
      tick();
   endtask

   task automatic test_random();
      for (int n = 0; n < 6; n++) begin
         bbase = $urandom; qbase = $urandom;
         fetch_group(CW'($urandom), 2, -1);
         drain_front();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_wrap();
      test_back_to_back();
      test_consume_empty();
      test_flush();
      test_reset_drain();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
